// File: rtl/alu_result_stage.sv
// ============================================================================
// Module   : alu_result_stage
// Brief    : Two-entry skid-buffered ALU result stage feeding writeback; owns
//            the architectural flags register. Forwarding is built only when
//            CPU_ALU_RESULT_FWD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_stage #(
  parameter int WORD_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 4,
  parameter int FLAGS_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_WIDTH-1:0]    in_result,
  input  logic [FLAGS_WIDTH-1:0]   in_flags,
  input  logic [REG_IDX_WIDTH-1:0] in_rd,
  input  logic                     in_wr_rd,
  input  logic                     in_wr_flags,
  input  logic                     flags_wr_en,
  input  logic [FLAGS_WIDTH-1:0]   flags_wr_data,
  output logic [FLAGS_WIDTH-1:0]   flags_q,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [WORD_WIDTH-1:0]    wb_result,
  output logic [REG_IDX_WIDTH-1:0] wb_rd,
  output logic                     wb_wr_rd,
  output logic [1:0]               occupancy,
  output logic                     fwd_valid,
  output logic [REG_IDX_WIDTH-1:0] fwd_rd,
  output logic [WORD_WIDTH-1:0]    fwd_result
);

  logic                     r_head_valid, r_skid_valid;
  logic [WORD_WIDTH-1:0]    r_head_result, r_skid_result;
  logic [REG_IDX_WIDTH-1:0] r_head_rd, r_skid_rd;
  logic                     r_head_wr_rd, r_skid_wr_rd;
  logic                     r_in_ready;
  logic [FLAGS_WIDTH-1:0]   r_flags;

  logic                     w_head_valid, w_skid_valid;
  logic [WORD_WIDTH-1:0]    w_head_result, w_skid_result;
  logic [REG_IDX_WIDTH-1:0] w_head_rd, w_skid_rd;
  logic                     w_head_wr_rd, w_skid_wr_rd;
  logic [FLAGS_WIDTH-1:0]   w_flags;
  logic                     w_accept, w_pop;

  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = r_head_valid & wb_ready;

  // The skid entry is only ever valid while the head is valid, so the
  // empty case never needs to look at the skid.
  always_comb begin
    w_head_valid  = r_head_valid;
    w_head_result = r_head_result;
    w_head_rd     = r_head_rd;
    w_head_wr_rd  = r_head_wr_rd;
    w_skid_valid  = r_skid_valid;
    w_skid_result = r_skid_result;
    w_skid_rd     = r_skid_rd;
    w_skid_wr_rd  = r_skid_wr_rd;
    if (flush) begin
      w_head_valid = 1'b0;
      w_skid_valid = 1'b0;
    end else if (!r_head_valid) begin
      if (w_accept) begin
        w_head_valid  = 1'b1;
        w_head_result = in_result;
        w_head_rd     = in_rd;
        w_head_wr_rd  = in_wr_rd;
      end
    end else if (!r_skid_valid) begin
      if (w_accept && w_pop) begin
        w_head_result = in_result;
        w_head_rd     = in_rd;
        w_head_wr_rd  = in_wr_rd;
      end else if (w_accept) begin
        w_skid_valid  = 1'b1;
        w_skid_result = in_result;
        w_skid_rd     = in_rd;
        w_skid_wr_rd  = in_wr_rd;
      end else if (w_pop) begin
        w_head_valid = 1'b0;
      end
    end else if (w_pop) begin
      w_head_result = r_skid_result;
      w_head_rd     = r_skid_rd;
      w_head_wr_rd  = r_skid_wr_rd;
      w_skid_valid  = 1'b0;
    end
  end

  // An accepted result's flags beat a same-cycle direct write; a flushed
  // accept never reaches the flags register.
  always_comb begin
    w_flags = r_flags;
    if (w_accept && in_wr_flags && !flush)
      w_flags = in_flags;
    else if (flags_wr_en)
      w_flags = flags_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head_valid  <= 1'b0;
      r_head_result <= '0;
      r_head_rd     <= '0;
      r_head_wr_rd  <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_skid_result <= '0;
      r_skid_rd     <= '0;
      r_skid_wr_rd  <= 1'b0;
      r_in_ready    <= 1'b1;
      r_flags       <= '0;
    end else begin
      r_head_valid  <= w_head_valid;
      r_head_result <= w_head_result;
      r_head_rd     <= w_head_rd;
      r_head_wr_rd  <= w_head_wr_rd;
      r_skid_valid  <= w_skid_valid;
      r_skid_result <= w_skid_result;
      r_skid_rd     <= w_skid_rd;
      r_skid_wr_rd  <= w_skid_wr_rd;
      r_in_ready    <= ~w_skid_valid;
      r_flags       <= w_flags;
    end
  end

  assign in_ready  = r_in_ready;
  assign flags_q   = r_flags;
  assign wb_valid  = r_head_valid;
  assign wb_result = r_head_result;
  assign wb_rd     = r_head_rd;
  assign wb_wr_rd  = r_head_wr_rd;
  assign occupancy = {r_skid_valid, r_head_valid & ~r_skid_valid};

`ifdef CPU_ALU_RESULT_FWD_EN
  // Youngest writer wins: skid entry over head entry.
  logic w_skid_fwd, w_head_fwd;
  assign w_skid_fwd = r_skid_valid & r_skid_wr_rd;
  assign w_head_fwd = r_head_valid & r_head_wr_rd;
  assign fwd_valid  = w_skid_fwd | w_head_fwd;
  assign fwd_rd     = w_skid_fwd ? r_skid_rd     : (w_head_fwd ? r_head_rd     : '0);
  assign fwd_result = w_skid_fwd ? r_skid_result : (w_head_fwd ? r_head_result : '0);
`else
  assign fwd_valid  = 1'b0;
  assign fwd_rd     = '0;
  assign fwd_result = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// ============================================================================
// Module   : tb_alu_result_stage
// Brief    : Directed self-checking bench for alu_result_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_wr_rd, in_wr_flags;
  logic [31:0] in_result, wb_result, fwd_result;
  logic [3:0]  in_flags, in_rd, flags_wr_data, flags_q, wb_rd, fwd_rd;
  logic        flags_wr_en, wb_valid, wb_ready, wb_wr_rd, fwd_valid;
  logic [1:0]  occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_result_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_rd(in_rd), .in_wr_rd(in_wr_rd),
    .in_wr_flags(in_wr_flags), .flags_wr_en(flags_wr_en),
    .flags_wr_data(flags_wr_data), .flags_q(flags_q),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
    .wb_rd(wb_rd), .wb_wr_rd(wb_wr_rd), .occupancy(occupancy),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_result(fwd_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] res, input logic [3:0] rd, input logic wr);
    in_valid  = 1'b1;
    in_result = res;
    in_rd     = rd;
    in_wr_rd  = wr;
    step();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_result = '0; in_flags = '0;
    in_rd = '0; in_wr_rd = 1'b0; in_wr_flags = 1'b0; flags_wr_en = 1'b0;
    flags_wr_data = '0; wb_ready = 1'b1;
    step(); step();
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_flags", 32'(flags_q), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wb_result", wb_result, 32'd0);
    check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    rst = 1'b0;

    // single result, one-cycle latency
    push(32'h5, 4'd3, 1'b1);
    check("t1_wb_valid", 32'(wb_valid), 32'd1);
    check("t1_wb_result", wb_result, 32'h5);
    check("t1_wb_rd", 32'(wb_rd), 32'd3);
    check("t1_occ", 32'(occupancy), 32'd1);
    step();
    check("t1_drain_occ", 32'(occupancy), 32'd0);

    // back-to-back throughput with wb_ready held high
    for (int i = 0; i < 3; i++) begin
      push(32'(10 + i), 4'(i), 1'b1);
      check("thru_result", wb_result, 32'(10 + i));
      check("thru_occ", 32'(occupancy), 32'd1);
    end
    step();
    check("thru_empty", 32'(wb_valid), 32'd0);

    // fill to two with writeback stalled, then drain in order
    wb_ready = 1'b0;
    push(32'h1, 4'd1, 1'b1);
    push(32'h2, 4'd2, 1'b1);
    check("t2_occ", 32'(occupancy), 32'd2);
    check("t2_in_ready", 32'(in_ready), 32'd0);
    check("t2_head_hold", wb_result, 32'h1);
    wb_ready = 1'b1;
    step();
    check("t2_pop_b", wb_result, 32'h2);
    check("t2_occ1", 32'(occupancy), 32'd1);
    check("t2_ready_back", 32'(in_ready), 32'd1);
    step();
    check("t2_empty", 32'(wb_valid), 32'd0);

    // ALU flags win over same-cycle direct write
    in_flags = 4'b1010; in_wr_flags = 1'b1;
    flags_wr_en = 1'b1; flags_wr_data = 4'b0101;
    push(32'h0, 4'd0, 1'b0);
    in_wr_flags = 1'b0; flags_wr_en = 1'b0;
    check("t3_flags", 32'(flags_q), 32'b1010);
    flags_wr_en = 1'b1; flags_wr_data = 4'b0101;
    step();
    flags_wr_en = 1'b0;
    check("t3_direct", 32'(flags_q), 32'b0101);

    // forwarding: both entries write rd 2, skid is youngest
    wb_ready = 1'b0;
    push(32'h7, 4'd2, 1'b1);
    push(32'h9, 4'd2, 1'b1);
`ifdef CPU_ALU_RESULT_FWD_EN
    check("t5_fwd_valid", 32'(fwd_valid), 32'd1);
    check("t5_fwd_rd", 32'(fwd_rd), 32'd2);
    check("t5_fwd_result", fwd_result, 32'h9);
`else
    check("t5_fwd_valid", 32'(fwd_valid), 32'd0);
    check("t5_fwd_result", fwd_result, 32'h0);
`endif

    // flush with simultaneous pop
    flush = 1'b1; wb_ready = 1'b1;
    step();
    flush = 1'b0;
    check("t4_occ", 32'(occupancy), 32'd0);
    check("t4_wb_valid", 32'(wb_valid), 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd1);
    check("t4_flags", 32'(flags_q), 32'b0101);

    // accept in flush cycle is dropped, direct flags write still lands
    flush = 1'b1; in_flags = 4'b1111; in_wr_flags = 1'b1;
    flags_wr_en = 1'b1; flags_wr_data = 4'b0011;
    push(32'hAA, 4'd4, 1'b1);
    flush = 1'b0; in_wr_flags = 1'b0; flags_wr_en = 1'b0;
    check("flush_acc_occ", 32'(occupancy), 32'd0);
    check("flush_acc_flags", 32'(flags_q), 32'b0011);

    // forwarding falls back to head when skid does not write a register
    wb_ready = 1'b0;
    push(32'h7, 4'd2, 1'b1);
    push(32'h9, 4'd5, 1'b0);
    check("fwd2_occ", 32'(occupancy), 32'd2);
`ifdef CPU_ALU_RESULT_FWD_EN
    check("fwd2_valid", 32'(fwd_valid), 32'd1);
    check("fwd2_rd", 32'(fwd_rd), 32'd2);
    check("fwd2_result", fwd_result, 32'h7);
`else
    check("fwd2_valid", 32'(fwd_valid), 32'd0);
`endif

    // asynchronous reset while full
    #2 rst = 1'b1;
    #1;
    check("t6_wb_valid", 32'(wb_valid), 32'd0);
    check("t6_flags", 32'(flags_q), 32'd0);
    check("t6_occ", 32'(occupancy), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
